// File: rtl/demux_1to8_deserializer.sv
// demux_1to8_deserializer: steers serial bits into 8 lanes and publishes each completed byte
module demux_1to8_deserializer #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in,
  input  logic       in_valid,
  input  logic       clear,
  output logic [7:0] out,
  output logic       out_valid,
  output logic [2:0] sel,
  output logic       busy
);
  typedef enum logic {IDLE, COLLECT} state_t;
  state_t state, state_n;
  logic [2:0] cnt, cnt_n;
  logic [7:0] hold, hold_w, hold_n, out_n;
  logic out_valid_n, take, done;
  assign sel = MSB_FIRST ? 3'd7 - cnt : cnt;
  assign busy = state == COLLECT;
  assign take = in_valid && !clear;
  assign done = take && cnt == 3'd7;
  // holding register with the incoming bit merged into the selected lane
  always_comb begin
    hold_w = hold;
    hold_w[sel] = in;
  end
  // next state: clear aborts, the 8th bit completes and restarts, other bits accumulate
  always_comb begin
    state_n = clear || done ? IDLE : take ? COLLECT : state;
    cnt_n = clear || done ? 3'd0 : take ? cnt + 3'd1 : cnt;
    hold_n = clear || done ? 8'h00 : take ? hold_w : hold;
    out_n = done ? hold_w : out;
    out_valid_n = done;
  end
  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 3'd0;
      hold <= 8'h00;
      out <= 8'h00;
      out_valid <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      hold <= hold_n;
      out <= out_n;
      out_valid <= out_valid_n;
    end
  end
endmodule

// File: tb/tb_demux_1to8_deserializer.sv
// tb_demux_1to8_deserializer: randomized checks of both lane orders against a bit-queue model
module tb_demux_1to8_deserializer;
  logic clk = 0, rst = 0, din = 0, in_valid = 0, clear = 0;
  logic [7:0] out0, out1;
  logic ov0, ov1, busy0, busy1;
  logic [2:0] sel0, sel1;
  logic [25:0] dutv;
  int vectors = 0, errors = 0;
  bit q[$];
  logic [7:0] m_out0 = 0, m_out1 = 0;
  logic m_ov = 0;

  always #5 clk = ~clk;

  demux_1to8_deserializer #(.MSB_FIRST(1'b0)) u0 (
    .clk(clk), .rst(rst), .in(din), .in_valid(in_valid), .clear(clear),
    .out(out0), .out_valid(ov0), .sel(sel0), .busy(busy0));
  demux_1to8_deserializer #(.MSB_FIRST(1'b1)) u1 (
    .clk(clk), .rst(rst), .in(din), .in_valid(in_valid), .clear(clear),
    .out(out1), .out_valid(ov1), .sel(sel1), .busy(busy1));

  assign dutv = {out0, ov0, sel0, busy0, out1, ov1, sel1, busy1};

  // the i-th accepted bit goes to lane i, or lane 7-i when msb-first
  function automatic logic [7:0] word_of(bit msb);
    logic [7:0] w = 8'h00;
    for (int i = 0; i < q.size(); i++) w[msb ? 7 - i : i] = q[i];
    return w;
  endfunction

  function automatic logic [25:0] expv();
    logic [2:0] n = 3'(q.size());
    logic b = q.size() != 0;
    return {m_out0, m_ov, n, b, m_out1, m_ov, 3'd7 - n, b};
  endfunction

  task automatic step(input logic v, input logic b, input logic c, input logic r);
    @(negedge clk);
    in_valid = v; din = b; clear = c; rst = r;
    @(posedge clk);
    if (r) begin
      q.delete(); m_out0 = 0; m_out1 = 0; m_ov = 0;
    end else if (c) begin
      q.delete(); m_ov = 0;
    end else if (v) begin
      q.push_back(b);
      m_ov = 0;
      if (q.size() == 8) begin
        m_out0 = word_of(0); m_out1 = word_of(1); m_ov = 1; q.delete();
      end
    end else m_ov = 0;
    #1;
  endtask

  task automatic test_reset();
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    vectors++;
    if (dutv !== expv()) begin errors++; $display("FAIL reset_model: dut %h model %h", dutv, expv()); end
    vectors++;
    if ({out0, ov0, sel0, busy0, sel1, busy1} !== {8'h00, 1'b0, 3'd0, 1'b0, 3'd7, 1'b0}) begin
      errors++; $display("FAIL reset_values: got %h expected %h", {out0, ov0, sel0, busy0, sel1, busy1}, {8'h00, 1'b0, 3'd0, 1'b0, 3'd7, 1'b0});
    end
    step(0, 0, 0, 0);
  endtask

  task automatic test_basic();
    logic [7:0] pat = 8'h4D;
    for (int i = 0; i < 8; i++) begin
      step(1, pat[i], 0, 0);
      vectors++;
      if (dutv !== expv()) begin errors++; $display("FAIL basic_bit%0d: dut %h model %h", i, dutv, expv()); end
    end
    vectors++;
    if ({out0, out1, ov0, ov1} !== {8'h4D, 8'hB2, 2'b11}) begin
      errors++; $display("FAIL basic_word: got %h expected %h", {out0, out1, ov0, ov1}, {8'h4D, 8'hB2, 2'b11});
    end
    step(0, 0, 0, 0);
    vectors++;
    if ({out0, out1, ov0, ov1, sel0, sel1} !== {8'h4D, 8'hB2, 2'b00, 3'd0, 3'd7}) begin
      errors++; $display("FAIL basic_after: got %h expected %h", {out0, out1, ov0, ov1, sel0, sel1}, {8'h4D, 8'hB2, 2'b00, 3'd0, 3'd7});
    end
  endtask

  task automatic test_gaps();
    logic [7:0] w = 8'hA5;
    int pulses = 0;
    step(0, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 5)) begin
        step(0, 1'($urandom), 0, 0);
        vectors++;
        if (dutv !== expv()) begin errors++; $display("FAIL gaps_idle%0d: dut %h model %h", i, dutv, expv()); end
        pulses += int'(ov0);
      end
      step(1, w[i], 0, 0);
      vectors++;
      if (dutv !== expv()) begin errors++; $display("FAIL gaps_bit%0d: dut %h model %h", i, dutv, expv()); end
      pulses += int'(ov0);
      if (i < 7) begin
        vectors++;
        if (out0 !== 8'h00) begin errors++; $display("FAIL gaps_hold%0d: got %h expected 00", i, out0); end
      end
    end
    step(0, 0, 0, 0);
    pulses += int'(ov0);
    vectors++;
    if (pulses != 1 || out0 !== 8'hA5) begin
      errors++; $display("FAIL gaps_word: pulses %0d out %h expected 1 pulse out a5", pulses, out0);
    end
  endtask

  task automatic test_clear();
    logic [7:0] w = 8'h3C;
    for (int i = 0; i < 5; i++) begin
      step(1, 1'($urandom), 0, 0);
      vectors++;
      if (dutv !== expv()) begin errors++; $display("FAIL clear_pre%0d: dut %h model %h", i, dutv, expv()); end
    end
    step(1, 1, 1, 0);
    vectors++;
    if ({out0, ov0, busy0, sel0} !== {8'hA5, 1'b0, 1'b0, 3'd0}) begin
      errors++; $display("FAIL clear_abort: got %h expected %h", {out0, ov0, busy0, sel0}, {8'hA5, 1'b0, 1'b0, 3'd0});
    end
    for (int i = 0; i < 8; i++) begin
      step(1, w[i], 0, 0);
      vectors++;
      if (dutv !== expv()) begin errors++; $display("FAIL clear_bit%0d: dut %h model %h", i, dutv, expv()); end
    end
    vectors++;
    if ({out0, ov0} !== {8'h3C, 1'b1}) begin errors++; $display("FAIL clear_word: got %h expected %h", {out0, ov0}, {8'h3C, 1'b1}); end
    for (int i = 0; i < 7; i++) step(1, 1, 0, 0);
    step(1, 1, 1, 0);
    vectors++;
    if ({out0, ov0, busy0} !== {8'h3C, 1'b0, 1'b0}) begin
      errors++; $display("FAIL clear_at7: got %h expected %h", {out0, ov0, busy0}, {8'h3C, 1'b0, 1'b0});
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [3] = '{8'h01, 8'hFF, 8'h80};
    for (int k = 0; k < 24; k++) begin
      step(1, words[k / 8][k % 8], 0, 0);
      vectors++;
      if (dutv !== expv()) begin errors++; $display("FAIL b2b_cycle%0d: dut %h model %h", k + 1, dutv, expv()); end
      vectors++;
      if (ov0 !== (k % 8 == 7)) begin errors++; $display("FAIL b2b_pulse%0d: got %b expected %b", k + 1, ov0, k % 8 == 7); end
      if (k % 8 == 7) begin
        vectors++;
        if (out0 !== words[k / 8]) begin errors++; $display("FAIL b2b_word%0d: got %h expected %h", k / 8, out0, words[k / 8]); end
      end
    end
  endtask

  task automatic test_rst_mid();
    logic [7:0] a = 8'hC3, b = 8'h5A;
    for (int i = 0; i < 7; i++) step(1, a[i], 0, 0);
    step(1, a[7], 0, 1);
    vectors++;
    if ({out0, sel0, busy0, ov0, out1, sel1} !== {8'h00, 3'd0, 1'b0, 1'b0, 8'h00, 3'd7}) begin
      errors++; $display("FAIL rst_mid: got %h expected %h", {out0, sel0, busy0, ov0, out1, sel1}, {8'h00, 3'd0, 1'b0, 1'b0, 8'h00, 3'd7});
    end
    for (int i = 0; i < 8; i++) begin
      step(1, b[i], 0, 0);
      vectors++;
      if (dutv !== expv()) begin errors++; $display("FAIL rst_bit%0d: dut %h model %h", i, dutv, expv()); end
    end
    vectors++;
    if ({out0, ov0} !== {8'h5A, 1'b1}) begin errors++; $display("FAIL rst_word: got %h expected %h", {out0, ov0}, {8'h5A, 1'b1}); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      step($urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0);
      vectors++;
      if (dutv !== expv()) begin errors++; $display("FAIL random%0d: dut %h model %h", k, dutv, expv()); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_clear();
    test_back_to_back();
    test_rst_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
